// File: rtl/spi_sram_arbiter.sv
// Shares one single-port SRAM between the SPI slave memory port (fixed latency, always wins)
// and the CPU bus (req/gnt). Define SPI_ARB_CPU_WRBUF_EN for a 1-entry posted CPU write buffer.
module spi_sram_arbiter #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [23-ADDR_W:0] SPI_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_mem_en,
    input  logic              spi_mem_wr,
    input  logic [23:0]       spi_mem_addr,
    input  logic [7:0]        spi_mem_wdata,
    output logic [7:0]        spi_mem_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              spi_oor,
    input  logic              spi_oor_clr
);

    typedef enum logic [1:0] {OwnIdle, OwnSpiRd, OwnCpuRd, OwnFwd} owner_e;

    owner_e owner_q, owner_d;

    logic       spi_in_win, spi_hit, spi_miss;
    logic       gnt, drain, fwd, cpu_direct;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0] buf_data;
    logic [7:0] spi_hold_q, cpu_rdata_q;
    logic       cpu_rvalid_q, spi_oor_q;

    assign spi_in_win = (spi_mem_addr[23:ADDR_W] == SPI_BASE);
    assign spi_hit    = spi_mem_en & spi_in_win;
    assign spi_miss   = spi_mem_en & ~spi_in_win;

`ifdef SPI_ARB_CPU_WRBUF_EN
    logic buf_valid, buf_match, buf_load;

    assign buf_match = buf_valid & (cpu_addr == buf_addr);
    assign drain     = buf_valid & ~spi_hit;

    // A read to a different address waits for the buffer so CPU ordering is preserved.
    always_comb begin
        gnt = 1'b0;
        if (cpu_req) begin
            if (cpu_we) begin
                gnt = ~buf_valid | ~spi_hit;
            end else if (buf_valid) begin
                gnt = buf_match;
            end else begin
                gnt = ~spi_hit;
            end
        end
    end

    // Writes that cannot reach RAM now are posted; a draining buffer is refilled on the same edge.
    assign buf_load   = gnt & cpu_we & (spi_hit | buf_valid);
    assign fwd        = gnt & ~cpu_we & buf_match;
    assign cpu_direct = gnt & ~buf_load & ~fwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= 8'h00;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_addr  <= cpu_addr;
            buf_data  <= cpu_wdata;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign gnt        = cpu_req & ~spi_hit;
    assign drain      = 1'b0;
    assign fwd        = 1'b0;
    assign cpu_direct = gnt;
    assign buf_addr   = '0;
    assign buf_data   = 8'h00;
`endif

    assign cpu_gnt = gnt & ~rst;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (!rst) begin
            if (spi_hit) begin
                ram_en    = 1'b1;
                ram_we    = spi_mem_wr;
                ram_addr  = spi_mem_addr[ADDR_W-1:0];
                ram_wdata = spi_mem_wdata;
            end else if (drain) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = buf_addr;
                ram_wdata = buf_data;
            end else if (cpu_direct) begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
            end
        end
    end

    always_comb begin
        owner_d = OwnIdle;
        if (spi_hit && !spi_mem_wr) begin
            owner_d = OwnSpiRd;
        end else if (cpu_direct && !cpu_we) begin
            owner_d = OwnCpuRd;
        end else if (fwd) begin
            owner_d = OwnFwd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OwnIdle;
            spi_hold_q   <= 8'h00;
            cpu_rdata_q  <= 8'h00;
            cpu_rvalid_q <= 1'b0;
            spi_oor_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            cpu_rvalid_q <= (cpu_direct & ~cpu_we) | fwd;
            spi_oor_q    <= spi_miss | (spi_oor_q & ~spi_oor_clr);
            if (spi_miss && !spi_mem_wr) begin
                spi_hold_q <= 8'hFF;
            end else if (owner_q == OwnSpiRd) begin
                spi_hold_q <= ram_rdata;
            end
            if (fwd) begin
                cpu_rdata_q <= buf_data;
            end else if (owner_q == OwnCpuRd) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM data is bypassed in the cycle after a read and held from the register afterwards.
    assign spi_mem_rdata = (owner_q == OwnSpiRd) ? ram_rdata : spi_hold_q;
    assign cpu_rdata     = (owner_q == OwnCpuRd) ? ram_rdata : cpu_rdata_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign spi_oor       = spi_oor_q;

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Self-checking bench for spi_sram_arbiter: directed scenarios plus randomized traffic checked
// against a memory-level reference model (golden memory, posted-write flag, sticky flag).
`timescale 1ns/1ps
module tb_spi_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_mem_en, spi_mem_wr;
    logic [23:0] spi_mem_addr;
    logic [7:0]  spi_mem_wdata, spi_mem_rdata;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        spi_oor, spi_oor_clr;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:65535];

    logic [7:0]  gmem [0:255];
    logic [7:0]  exp_spi;
    logic        exp_oor;
    int          errors = 0;
    int          checks = 0;

    spi_sram_arbiter #(.ADDR_W(16), .SPI_BASE(8'h00)) dut (
        .clk(clk), .rst(rst),
        .spi_mem_en(spi_mem_en), .spi_mem_wr(spi_mem_wr), .spi_mem_addr(spi_mem_addr),
        .spi_mem_wdata(spi_mem_wdata), .spi_mem_rdata(spi_mem_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .spi_oor(spi_oor), .spi_oor_clr(spi_oor_clr)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with a preload port for the bench.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        spi_mem_en = 1'b0; spi_mem_wr = 1'b0; spi_mem_addr = 24'h0; spi_mem_wdata = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h00;
        spi_oor_clr = 1'b0;
    endtask

    task automatic spi_drive(input logic wr, input logic [23:0] a, input logic [7:0] d);
        spi_mem_en = 1'b1; spi_mem_wr = wr; spi_mem_addr = a; spi_mem_wdata = d;
    endtask

    task automatic cpu_drive(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (spi_mem_rdata !== 8'h00) begin errors++;
            $display("FAIL rst_spi_rdata: got %h want 00", spi_mem_rdata); end
        checks++; if (cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++;
            $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
        checks++; if (spi_oor !== 1'b0) begin errors++;
            $display("FAIL rst_oor: got %b want 0", spi_oor); end
        @(negedge clk); rst = 1'b0;
        // Dirty the state: out-of-window SPI read plus a CPU read.
        @(negedge clk); spi_drive(1'b0, 24'h010000, 8'h00); cpu_drive(1'b0, 16'h0005, 8'h00);
        tick();
        @(negedge clk); idle_inputs(); cpu_drive(1'b0, 16'h0006, 8'h00);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL rst_pre_gnt: got %b want 1", cpu_gnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++;
            $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        checks++; if (cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL rst_gnt: got %b want 0", cpu_gnt); end
        checks++; if (cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL rst_async_rvalid: got %b want 0", cpu_rvalid); end
        tick();
        checks++; if (cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_rvalid: got %b want 0", cpu_rvalid); end
        checks++; if (spi_mem_rdata !== 8'h00) begin errors++;
            $display("FAIL rst_mid_spi_rdata: got %h want 00", spi_mem_rdata); end
        checks++; if (spi_oor !== 1'b0) begin errors++;
            $display("FAIL rst_mid_oor: got %b want 0", spi_oor); end
        @(negedge clk); idle_inputs(); rst = 1'b0;
        exp_spi = 8'h00; exp_oor = 1'b0;
        tick();
    endtask

    task automatic test_spi_priority();
        @(negedge clk); spi_drive(1'b0, 24'h000010, 8'h00); cpu_drive(1'b0, 16'h0011, 8'h00);
        #1;
        checks++; if (cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL prio_gnt: got %b want 0", cpu_gnt); end
        checks++; if (ram_addr !== 16'h0010 || ram_en !== 1'b1) begin errors++;
            $display("FAIL prio_ram: got en=%b addr=%h want en=1 addr=0010", ram_en, ram_addr); end
        tick();
        exp_spi = 8'hA5;
        checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
            $display("FAIL prio_spi_rdata: got %h want %h", spi_mem_rdata, exp_spi); end
        @(negedge clk); spi_mem_en = 1'b0;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL prio_retry_gnt: got %b want 1", cpu_gnt); end
        tick();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== gmem[8'h11]) begin errors++;
            $display("FAIL prio_cpu_read: got v=%b d=%h want v=1 d=%h",
                     cpu_rvalid, cpu_rdata, gmem[8'h11]); end
        checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
            $display("FAIL prio_spi_hold: got %h want %h", spi_mem_rdata, exp_spi); end
        @(negedge clk); idle_inputs();
        tick();
        checks++; if (cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL prio_rvalid_pulse: got %b want 0", cpu_rvalid); end
    endtask

    task automatic test_spi_write_cpu_read();
        @(negedge clk); spi_drive(1'b1, 24'h000020, 8'h3C);
        tick();
        gmem[8'h20] = 8'h3C;
        checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
            $display("FAIL wr_spi_hold: got %h want %h", spi_mem_rdata, exp_spi); end
        @(negedge clk); idle_inputs(); cpu_drive(1'b0, 16'h0020, 8'h00);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL wr_cpu_gnt: got %b want 1", cpu_gnt); end
        tick();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) begin errors++;
            $display("FAIL wr_cpu_read: got v=%b d=%h want v=1 d=3c", cpu_rvalid, cpu_rdata); end
        @(negedge clk); idle_inputs();
        tick();
    endtask

    task automatic test_oor();
        @(negedge clk); spi_drive(1'b0, 24'h010000, 8'h00); cpu_drive(1'b0, 16'h0030, 8'h00);
        #1;
        checks++; if (cpu_gnt !== 1'b1 || ram_addr !== 16'h0030 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL oor_cpu_port: got gnt=%b addr=%h we=%b want 1/0030/0",
                     cpu_gnt, ram_addr, ram_we); end
        tick();
        exp_spi = 8'hFF; exp_oor = 1'b1;
        checks++; if (spi_mem_rdata !== 8'hFF || spi_oor !== 1'b1) begin errors++;
            $display("FAIL oor_read: got d=%h oor=%b want ff/1", spi_mem_rdata, spi_oor); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== gmem[8'h30]) begin errors++;
            $display("FAIL oor_cpu_read: got v=%b d=%h want 1/%h",
                     cpu_rvalid, cpu_rdata, gmem[8'h30]); end
        @(negedge clk); idle_inputs();
        tick();
        checks++; if (spi_mem_rdata !== 8'hFF || spi_oor !== 1'b1) begin errors++;
            $display("FAIL oor_hold: got d=%h oor=%b want ff/1", spi_mem_rdata, spi_oor); end
        @(negedge clk); spi_oor_clr = 1'b1;
        tick();
        checks++; if (spi_oor !== 1'b0) begin errors++;
            $display("FAIL oor_clr: got %b want 0", spi_oor); end
        @(negedge clk); spi_drive(1'b1, 24'hFF0000, 8'h99);
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++;
            $display("FAIL oor_wr_dropped: got ram_en=%b want 0", ram_en); end
        tick();
        checks++; if (spi_oor !== 1'b1) begin errors++;
            $display("FAIL oor_set_wins: got %b want 1", spi_oor); end
        @(negedge clk); idle_inputs(); spi_oor_clr = 1'b1;
        tick();
        @(negedge clk); idle_inputs();
        exp_oor = 1'b0;
    endtask

    task automatic test_wrbuf();
        @(negedge clk); spi_drive(1'b0, 24'h000050, 8'h00); cpu_drive(1'b1, 16'h0040, 8'h77);
        #1;
`ifdef SPI_ARB_CPU_WRBUF_EN
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL wb_post_gnt: got %b want 1", cpu_gnt); end
`else
        checks++; if (cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL wb_post_gnt: got %b want 0", cpu_gnt); end
`endif
        tick();
        exp_spi = gmem[8'h50];
        checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
            $display("FAIL wb_spi_read: got %h want %h", spi_mem_rdata, exp_spi); end
        @(negedge clk); spi_mem_en = 1'b0;
`ifdef SPI_ARB_CPU_WRBUF_EN
        cpu_drive(1'b0, 16'h0040, 8'h00);
`endif
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL wb_second_gnt: got %b want 1", cpu_gnt); end
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'h0040 ||
                      ram_wdata !== 8'h77) begin errors++;
            $display("FAIL wb_ram_write: got en=%b we=%b a=%h d=%h want 1/1/0040/77",
                     ram_en, ram_we, ram_addr, ram_wdata); end
        tick();
        gmem[8'h40] = 8'h77;
`ifndef SPI_ARB_CPU_WRBUF_EN
        @(negedge clk); cpu_drive(1'b0, 16'h0040, 8'h00);
        tick();
`endif
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h77) begin errors++;
            $display("FAIL wb_read_back: got v=%b d=%h want 1/77", cpu_rvalid, cpu_rdata); end
        @(negedge clk); idle_inputs();
        tick();
`ifdef SPI_ARB_CPU_WRBUF_EN
        // Read to another address must wait behind the posted write.
        @(negedge clk); spi_drive(1'b0, 24'h000051, 8'h00); cpu_drive(1'b1, 16'h0041, 8'h12);
        tick();
        gmem[8'h41] = 8'h12;
        @(negedge clk); spi_drive(1'b0, 24'h000052, 8'h00); cpu_drive(1'b0, 16'h0042, 8'h00);
        #1;
        checks++; if (cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL wb_order_gnt_spi: got %b want 0", cpu_gnt); end
        tick();
        @(negedge clk); spi_mem_en = 1'b0;
        #1;
        checks++; if (cpu_gnt !== 1'b0 || ram_addr !== 16'h0041 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL wb_order_drain: got gnt=%b a=%h we=%b want 0/0041/1",
                     cpu_gnt, ram_addr, ram_we); end
        tick();
        exp_spi = gmem[8'h52];
        @(negedge clk);
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL wb_order_gnt: got %b want 1", cpu_gnt); end
        tick();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== gmem[8'h42]) begin errors++;
            $display("FAIL wb_order_read: got v=%b d=%h want 1/%h",
                     cpu_rvalid, cpu_rdata, gmem[8'h42]); end
        @(negedge clk); idle_inputs();
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        int denied = 0;
        int strobes = 0;
        logic [15:0] ca = 16'h0080;
        logic exp_rv;
        logic [7:0] exp_rd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cpu_drive(1'b0, ca, 8'h00);
            if (c % 8 == 0) begin
                spi_drive(1'b0, 24'(c), 8'h00);
                strobes++;
            end else begin
                spi_mem_en = 1'b0;
            end
            #1;
            if (cpu_gnt !== 1'b1) denied++;
            checks++; if (cpu_gnt !== !spi_mem_en) begin errors++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", c, cpu_gnt, !spi_mem_en); end
            exp_rv = !spi_mem_en;
            exp_rd = gmem[ca[7:0]];
            if (spi_mem_en) exp_spi = gmem[8'(c)];
            if (exp_rv) ca = ca + 16'd1;
            tick();
            checks++; if (cpu_rvalid !== exp_rv || (exp_rv && cpu_rdata !== exp_rd)) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got v=%b d=%h want v=%b d=%h",
                         c, cpu_rvalid, cpu_rdata, exp_rv, exp_rd); end
            checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
                $display("FAIL b2b_spi[%0d]: got %h want %h", c, spi_mem_rdata, exp_spi); end
        end
        checks++; if (denied != strobes) begin errors++;
            $display("FAIL b2b_denied: got %0d want %0d", denied, strobes); end
        @(negedge clk); idle_inputs();
        tick();
    endtask

    task automatic test_random(input int n);
        logic        hreq = 1'b0;
        logic        hwe = 1'b0;
        logic [15:0] haddr = 16'h0080;
        logic [7:0]  hwd = 8'h00;
        logic        pend = 1'b0;
        logic [15:0] pend_addr = 16'h0;
        logic        hit, miss, clr, exp_gnt, exp_rv;
        logic [7:0]  exp_rd;
        logic [23:0] sa;
        exp_rd = 8'h00;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!hreq && $urandom_range(9) < 7) begin
                hreq  = 1'b1;
                hwe   = 1'($urandom_range(1));
                haddr = 16'h0080 | 16'($urandom_range(127));
                hwd   = 8'($urandom);
            end
            if ($urandom_range(9) == 0) sa = {8'($urandom_range(255, 1)), 16'($urandom)};
            else                         sa = 24'($urandom_range(127));
            spi_drive(1'b0, sa, 8'($urandom));
            spi_mem_en = ($urandom_range(3) == 0);
            spi_mem_wr = 1'($urandom_range(1));
            clr = ($urandom_range(15) == 0);
            spi_oor_clr = clr;
            cpu_req = hreq; cpu_we = hwe; cpu_addr = haddr; cpu_wdata = hwd;
            hit  = spi_mem_en && (sa[23:16] == 8'h00);
            miss = spi_mem_en && !hit;
            exp_gnt = hreq && !hit;
`ifdef SPI_ARB_CPU_WRBUF_EN
            if (hreq) begin
                if (hwe)       exp_gnt = !pend || !hit;
                else if (pend) exp_gnt = (haddr == pend_addr);
            end
`endif
            #1;
            checks++; if (cpu_gnt !== exp_gnt) begin errors++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", c, cpu_gnt, exp_gnt); end
            exp_rv = 1'b0;
            if (hit && spi_mem_wr)  gmem[sa[7:0]] = spi_mem_wdata;
            if (hit && !spi_mem_wr) exp_spi = gmem[sa[7:0]];
            if (miss && !spi_mem_wr) exp_spi = 8'hFF;
            exp_oor = miss || (exp_oor && !clr);
            if (exp_gnt) begin
                if (hwe) gmem[haddr[7:0]] = hwd;
                else begin exp_rv = 1'b1; exp_rd = gmem[haddr[7:0]]; end
            end
`ifdef SPI_ARB_CPU_WRBUF_EN
            if (exp_gnt && hwe && (hit || pend)) begin
                pend = 1'b1; pend_addr = haddr;
            end else if (!hit) begin
                pend = 1'b0;
            end
`endif
            if (exp_gnt) hreq = 1'b0;
            tick();
            checks++; if (cpu_rvalid !== exp_rv || (exp_rv && cpu_rdata !== exp_rd)) begin
                errors++;
                $display("FAIL rnd_read[%0d]: got v=%b d=%h want v=%b d=%h",
                         c, cpu_rvalid, cpu_rdata, exp_rv, exp_rd); end
            checks++; if (spi_mem_rdata !== exp_spi) begin errors++;
                $display("FAIL rnd_spi[%0d]: got %h want %h", c, spi_mem_rdata, exp_spi); end
            checks++; if (spi_oor !== exp_oor) begin errors++;
                $display("FAIL rnd_oor[%0d]: got %b want %b", c, spi_oor, exp_oor); end
        end
        @(negedge clk); idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        idle_inputs();
        pl_en = 1'b0; pl_addr = 16'h0; pl_data = 8'h00;
        exp_spi = 8'h00; exp_oor = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            d = (i == 16) ? 8'hA5 : 8'($urandom);
            pl_en = 1'b1; pl_addr = 16'(i); pl_data = d;
            gmem[i] = d;
        end
        @(negedge clk); pl_en = 1'b0;
        #1;
        test_reset();
        test_spi_priority();
        test_spi_write_cpu_read();
        test_oor();
        test_wrbuf();
        test_back_to_back();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
